// File: rtl/btb_param.sv
// btb_param: direct-mapped branch target buffer with per-entry 2-bit
// hysteresis counters, a global enable, single-cycle flush and saturating
// statistics counters. Lookup is combinational; updates land on posedge.
module btb_param #(
    parameter int          ADDR_W   = 16,
    parameter int          IDX_W    = 4,
    parameter logic [1:0]  CNT_INIT = 2'b01,
    parameter int          STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              flush,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W;

    // Table storage, one slot per index.
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];

    logic [STAT_W-1:0] lookups_q, lookups_d;
    logic [STAT_W-1:0] hits_q, hits_d;
    logic [STAT_W-1:0] mispredicts_q, mispredicts_d;

    // Fetch-side decode.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    // Update-side decode and the next value of the addressed entry.
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;
    logic              u_we;
    logic              entry_valid_d;
    logic [TAG_W-1:0]  entry_tag_d;
    logic [ADDR_W-1:0] entry_target_d;
    logic [1:0]        entry_cnt_d;

    assign f_idx = fetch_pc[IDX_W-1:0];
    assign f_tag = fetch_pc[ADDR_W-1:IDX_W];
    assign u_idx = upd_pc[IDX_W-1:0];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W];

    // Combinational lookup from the flop table; sees pre-update contents.
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_hit    = en && fetch_valid && f_hit;
        pred_taken  = pred_hit && cnt_q[f_idx][1];
        pred_target = pred_hit ? target_q[f_idx] : '0;
    end

    // Next state of the entry addressed by the update port. Not-taken misses
    // leave the entry alone, so the write enable excludes them.
    always_comb begin
        u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_we           = en && upd_valid && !flush && (u_hit || upd_taken);
        entry_valid_d  = valid_q[u_idx];
        entry_tag_d    = tag_q[u_idx];
        entry_target_d = target_q[u_idx];
        entry_cnt_d    = cnt_q[u_idx];
        if (u_hit) begin
            if (upd_taken) begin
                entry_cnt_d    = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'b01;
                entry_target_d = upd_target;
            end else begin
                entry_cnt_d    = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'b01;
            end
        end else if (upd_taken) begin
            entry_valid_d  = 1'b1;
            entry_tag_d    = u_tag;
            entry_target_d = upd_target;
            entry_cnt_d    = 2'b10;
        end
    end

    // Table state: flush wins over a same-cycle update. Flush is an explicit
    // invalidate and acts even while prediction is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else if (u_we) begin
            valid_q[u_idx]  <= entry_valid_d;
            tag_q[u_idx]    <= entry_tag_d;
            target_q[u_idx] <= entry_target_d;
            cnt_q[u_idx]    <= entry_cnt_d;
        end
    end

    // Saturating statistics next-state; clear beats any increment.
    always_comb begin
        lookups_d     = lookups_q;
        hits_d        = hits_q;
        mispredicts_d = mispredicts_q;
        if (stat_clr) begin
            lookups_d     = '0;
            hits_d        = '0;
            mispredicts_d = '0;
        end else if (en) begin
            if (fetch_valid && (lookups_q != '1))
                lookups_d = lookups_q + 1'b1;
            if (pred_hit && (hits_q != '1))
                hits_d = hits_q + 1'b1;
            if (upd_valid && upd_mispredict && (mispredicts_q != '1))
                mispredicts_d = mispredicts_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else begin
            lookups_q     <= lookups_d;
            hits_q        <= hits_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_btb_param.sv
// Bench for btb_param: directed steps from the feature list followed by a
// randomized phase, all checked against an array-based reference model.
module tb_btb_param;

    localparam int         ADDR_W   = 16;
    localparam int         IDX_W    = 4;
    localparam logic [1:0] CNT_INIT = 2'b01;
    localparam int         STAT_W   = 8;
    localparam int         ENTRIES  = 2 ** IDX_W;
    localparam int         STAT_MAX = 2 ** STAT_W - 1;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              en, fetch_valid, upd_valid, upd_taken, upd_mispredict, flush, stat_clr;
    logic [ADDR_W-1:0] fetch_pc, upd_pc, upd_target;
    logic              pred_hit, pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [STAT_W-1:0] stat_lookups, stat_hits, stat_mispredicts;

    btb_param #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_INIT(CNT_INIT), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush(flush), .stat_clr(stat_clr),
        .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts)
    );

    int tests = 0;
    int failed = 0;

    // Reference model: what each table slot holds, plus event counts.
    bit m_valid  [ENTRIES];
    int m_tag    [ENTRIES];
    int m_target [ENTRIES];
    int m_cnt    [ENTRIES];
    int m_lookups, m_hits, m_mis;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = int'(CNT_INIT);
        end
        m_lookups = 0; m_hits = 0; m_mis = 0;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= STAT_MAX) ? STAT_MAX : v + 1;
    endfunction

    // Model state change on a clock edge, given the hit seen by fetch.
    function automatic void model_edge(bit exp_hit);
        int i, t;
        i = int'(upd_pc) % ENTRIES;
        t = int'(upd_pc) / ENTRIES;
        if (flush) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 0; m_cnt[k] = int'(CNT_INIT);
            end
        end else if (en && upd_valid) begin
            if (m_valid[i] && m_tag[i] == t) begin
                if (upd_taken) begin
                    m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                    m_target[i] = int'(upd_target);
                end else begin
                    m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1; m_tag[i] = t; m_target[i] = int'(upd_target); m_cnt[i] = 2;
            end
        end
        if (stat_clr) begin
            m_lookups = 0; m_hits = 0; m_mis = 0;
        end else if (en) begin
            if (fetch_valid) m_lookups = sat_inc(m_lookups);
            if (exp_hit) m_hits = sat_inc(m_hits);
            if (upd_valid && upd_mispredict) m_mis = sat_inc(m_mis);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs are already driven; check outputs mid-cycle, then
    // advance the model across the edge.
    task automatic tick(input string tag);
        int  i, t;
        bit  e_hit, e_taken;
        int  e_tgt;
        i = int'(fetch_pc) % ENTRIES;
        t = int'(fetch_pc) / ENTRIES;
        e_hit   = en && fetch_valid && m_valid[i] && (m_tag[i] == t);
        e_taken = e_hit && (m_cnt[i] >= 2);
        e_tgt   = e_hit ? m_target[i] : 0;
        #3;
        chk({tag, ".hit"},    32'(pred_hit),    32'(e_hit));
        chk({tag, ".taken"},  32'(pred_taken),  32'(e_taken));
        chk({tag, ".target"}, 32'(pred_target), e_tgt);
        chk({tag, ".lkp"},    32'(stat_lookups),     m_lookups);
        chk({tag, ".hits"},   32'(stat_hits),        m_hits);
        chk({tag, ".mis"},    32'(stat_mispredicts), m_mis);
        @(posedge clk);
        model_edge(e_hit);
        #1;
    endtask

    // Driver helpers.
    task automatic idle();
        en = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_mispredict = 1'b0; flush = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] pc, input string tag);
        idle(); fetch_valid = 1'b1; fetch_pc = pc; tick(tag);
    endtask

    task automatic update(input logic [ADDR_W-1:0] pc, input logic tk,
                          input logic [ADDR_W-1:0] tgt, input string tag);
        idle(); upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; tick(tag);
    endtask

    initial begin
        idle();
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state, first lookup misses and counts.
        idle(); fetch_valid = 1'b1; fetch_pc = 16'h0012; #2;
        chk("rst.hit_const", 32'(pred_hit), 0);
        chk("rst.tgt_const", 32'(pred_target), 0);
        #(-0) tick("rst");
        idle(); #1;
        chk("rst.lkp_const", 32'(stat_lookups), 1);
        chk("rst.hits_const", 32'(stat_hits), 0);

        // Allocate, then the next cycle hits.
        idle(); upd_valid = 1'b1; upd_pc = 16'h0012; upd_taken = 1'b1; upd_target = 16'h0040;
        fetch_valid = 1'b1; fetch_pc = 16'h0012;  // same-cycle lookup sees old contents
        tick("alloc");
        idle(); fetch_valid = 1'b1; fetch_pc = 16'h0012; #2;
        chk("alloc.hit_const", 32'(pred_hit), 1);
        chk("alloc.taken_const", 32'(pred_taken), 1);
        chk("alloc.tgt_const", 32'(pred_target), 32'h40);
        tick("alloc_fetch");

        // Hysteresis: saturate, then two not-taken to flip.
        for (int k = 0; k < 3; k++) update(16'h0012, 1'b1, 16'h0040, "sat_up");
        update(16'h0012, 1'b0, 16'h0000, "nt1");
        fetch(16'h0012, "after_nt1");
        update(16'h0012, 1'b0, 16'h0000, "nt2");
        idle(); fetch_valid = 1'b1; fetch_pc = 16'h0012; #2;
        chk("nt2.taken_const", 32'(pred_taken), 0);
        chk("nt2.hit_const", 32'(pred_hit), 1);
        tick("after_nt2");

        // Aliasing on the same index.
        update(16'h0112, 1'b1, 16'h0080, "alias_upd");
        fetch(16'h0012, "alias_old");
        fetch(16'h0112, "alias_new");
        update(16'h0212, 1'b0, 16'h0099, "alias_nt");
        fetch(16'h0112, "alias_keep");
        fetch(16'h0212, "alias_nt_miss");

        // Flush beats a same-cycle update.
        update(16'h0033, 1'b1, 16'h0123, "pre_flush");
        idle(); flush = 1'b1; upd_valid = 1'b1; upd_pc = 16'h0055; upd_taken = 1'b1; upd_target = 16'h0777;
        tick("flush_upd");
        fetch(16'h0112, "flush_f1");
        fetch(16'h0033, "flush_f2");
        fetch(16'h0055, "flush_f3");

        // Disabled: nothing changes.
        update(16'h0044, 1'b1, 16'h0444, "en_alloc");
        for (int k = 0; k < 4; k++) begin
            idle(); en = 1'b0; fetch_valid = 1'b1; fetch_pc = 16'h0044;
            upd_valid = 1'b1; upd_pc = 16'h0044; upd_taken = 1'b0; upd_mispredict = 1'b1;
            tick("en_off");
        end
        fetch(16'h0044, "en_back");

        // Mispredict counter saturation, then clear racing an increment.
        for (int k = 0; k < STAT_MAX + 6; k++) begin
            idle(); upd_valid = 1'b1; upd_mispredict = 1'b1; upd_pc = 16'h0077; upd_taken = 1'b0;
            tick("mis_sat");
        end
        idle(); #1;
        chk("mis_sat_const", 32'(stat_mispredicts), STAT_MAX);
        idle(); stat_clr = 1'b1; upd_valid = 1'b1; upd_mispredict = 1'b1; fetch_valid = 1'b1; fetch_pc = 16'h0044;
        tick("clr");
        idle(); #1;
        chk("clr_const", 32'(stat_mispredicts), 0);

        // Randomized traffic over a small PC set so entries collide and hit.
        for (int k = 0; k < 400; k++) begin
            idle();
            en             = ($urandom_range(0, 9) != 0);
            fetch_valid    = $urandom_range(0, 1);
            fetch_pc       = 16'(($urandom_range(0, 3) << IDX_W) | $urandom_range(0, ENTRIES - 1));
            upd_valid      = $urandom_range(0, 1);
            upd_pc         = 16'(($urandom_range(0, 3) << IDX_W) | $urandom_range(0, ENTRIES - 1));
            upd_taken      = $urandom_range(0, 1);
            upd_target     = 16'($urandom);
            upd_mispredict = $urandom_range(0, 1);
            flush          = ($urandom_range(0, 49) == 0);
            stat_clr       = ($urandom_range(0, 49) == 0);
            tick("rand");
        end

        // Reset in the middle of activity clears everything at once.
        update(16'h0066, 1'b1, 16'h0666, "pre_rst");
        idle(); fetch_valid = 1'b1; fetch_pc = 16'h0066; #2;
        chk("pre_rst.hit_const", 32'(pred_hit), 1);
        rst_n = 1'b0; #1;
        chk("mid_rst.hit", 32'(pred_hit), 0);
        chk("mid_rst.tgt", 32'(pred_target), 0);
        chk("mid_rst.lkp", 32'(stat_lookups), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch(16'h0066, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
